// File: rtl/uart_tx_arb_if.sv
// rtl/uart_tx_arb_if.sv - bundle of requester, config and transmitter signals for uart_tx_arb
//
// Purpose: groups every non-clock/reset signal of the two-requester UART
// transmit arbiter so the arbiter and its environment connect with one port.
//
// Signals:
//   req0_valid/req0_data/req0_ready  requester 0 byte handshake (valid&ready = transfer)
//   req1_valid/req1_data/req1_ready  requester 1 byte handshake
//   cfg_bps/cfg_wr                   baud select code and its write strobe
//   bps_set                          baud select presented to the transmitter
//   send_en/data_out                 one-cycle start pulse and byte to the transmitter
//   tx_done/tx_state                 transmitter end-of-frame pulse and busy flag
//   grant                            index of the most recently accepted requester
//   busy                             arbiter is not idle
//   timeout_err                      sticky tx_done watchdog flag
//
// Modports: slave = the arbiter, master = requesters/transmitter side.

interface uart_tx_arb_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic [1:0] cfg_bps;
    logic       cfg_wr;
    logic [1:0] bps_set;
    logic       send_en;
    logic [7:0] data_out;
    logic       tx_done;
    logic       tx_state;
    logic       grant;
    logic       busy;
    logic       timeout_err;

    modport slave (
        input  req0_valid, req0_data,
        output req0_ready,
        input  req1_valid, req1_data,
        output req1_ready,
        input  cfg_bps, cfg_wr,
        output bps_set, send_en, data_out,
        input  tx_done, tx_state,
        output grant, busy, timeout_err
    );

    modport master (
        output req0_valid, req0_data,
        input  req0_ready,
        output req1_valid, req1_data,
        input  req1_ready,
        output cfg_bps, cfg_wr,
        input  bps_set, send_en, data_out,
        output tx_done, tx_state,
        input  grant, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin two-requester arbiter feeding a UART transmitter
//
// Purpose: accepts one byte at a time from two requesters (round-robin),
// hands it to a UART transmitter with a one-cycle send_en pulse, waits for
// tx_done under a watchdog, and applies baud-select writes only while idle.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   uart_tx_arb_if.slave (requester handshakes, cfg, transmitter side,
//         grant/busy/timeout_err status)
//
// Parameter:
//   TO_CYCLES  tx_done watchdog limit in clk cycles (>= 2)

module uart_tx_arb #(
    parameter int unsigned TO_CYCLES = 200000
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_arb_if.slave bus
);

    localparam int CNT_W = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic             pend_q, pend_d;
    logic [1:0]       pend_bps_q, pend_bps_d;
    logic [1:0]       bps_q, bps_d;
    logic [7:0]       dout_q, dout_d;
    logic             grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;

    logic             rdy0, rdy1, send_en, pick1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_q       <= 1'b0;
            pend_q     <= 1'b0;
            pend_bps_q <= 2'b00;
            bps_q      <= 2'b00;
            dout_q     <= 8'h00;
            grant_q    <= 1'b0;
            cnt_q      <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            pend_q     <= pend_d;
            pend_bps_q <= pend_bps_d;
            bps_q      <= bps_d;
            dout_q     <= dout_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            terr_q     <= terr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        pend_d     = pend_q;
        pend_bps_d = pend_bps_q;
        bps_d      = bps_q;
        dout_d     = dout_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        terr_d     = terr_q;
        rdy0       = 1'b0;
        rdy1       = 1'b0;
        send_en    = 1'b0;
        // Requester 1 wins when it is alone or when the pointer favours it.
        pick1      = bus.req1_valid && (!bus.req0_valid || rr_q);

        case (state_q)
            ST_IDLE: begin
                // A config update (pending or fresh) takes the whole idle
                // cycle; a fresh write in the same cycle is the newest value.
                if (pend_q || bus.cfg_wr) begin
                    bps_d  = bus.cfg_wr ? bus.cfg_bps : pend_bps_q;
                    pend_d = 1'b0;
                end else if (!bus.tx_state && (bus.req0_valid || bus.req1_valid)) begin
                    rdy0    = !pick1;
                    rdy1    = pick1;
                    dout_d  = pick1 ? bus.req1_data : bus.req0_data;
                    grant_d = pick1;
                    rr_d    = !pick1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                send_en = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT;
                if (bus.cfg_wr) begin
                    pend_d     = 1'b1;
                    pend_bps_d = bus.cfg_bps;
                end
            end
            ST_WAIT: begin
                if (bus.cfg_wr) begin
                    pend_d     = 1'b1;
                    pend_bps_d = bus.cfg_bps;
                end
                // tx_done has priority over the watchdog expiring.
                if (bus.tx_done) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    terr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req0_ready  = rdy0;
    assign bus.req1_ready  = rdy1;
    assign bus.send_en     = send_en;
    assign bus.data_out    = dout_q;
    assign bus.bps_set     = bps_q;
    assign bus.grant       = grant_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - self-checking bench for uart_tx_arb

module tb_uart_tx_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arb_if ifa ();
    uart_tx_arb_if ift ();

    uart_tx_arb #(.TO_CYCLES(64)) u_dut    (.clk(clk), .rst(rst), .bus(ifa.slave));
    uart_tx_arb #(.TO_CYCLES(8))  u_dut_to (.clk(clk), .rst(rst), .bus(ift.slave));

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       txs;
        logic       txd;
        logic       cw;
        logic [1:0] cb;
        logic       r0;
        logic       r1;
        logic       se;
        logic       busy;
        logic       gr;
        logic [7:0] dout;
        logic [1:0] bps;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int td, nsend, se_run, max_run, na, nd, last_acc;
    logic drop0, drop1, bad0;
    logic [7:0] sd [2];
    logic       sg [2];
    int acc_c [3];
    int done_c [3];
    vec_t tbl [20];
    vec_t v;
    logic m_rr, m_pend, in_fl, e_r0, e_r1, e_se, e_busy, n_in, w, m_grant, n_grant;
    logic [1:0] m_pend_val, m_bps, n_bps;
    logic [7:0] m_dout, n_dout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        ifa.req0_valid = 0; ifa.req0_data = 0; ifa.req1_valid = 0; ifa.req1_data = 0;
        ifa.cfg_bps = 0; ifa.cfg_wr = 0; ifa.tx_done = 0; ifa.tx_state = 0;
        ift.req0_valid = 0; ift.req0_data = 0; ift.req1_valid = 0; ift.req1_data = 0;
        ift.cfg_bps = 0; ift.cfg_wr = 0; ift.tx_done = 0; ift.tx_state = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    function automatic vec_t mk(input logic v0, input logic [7:0] d0, input logic v1,
                                input logic [7:0] d1, input logic txs, input logic txd,
                                input logic cw, input logic [1:0] cb, input logic r0,
                                input logic r1, input logic se, input logic busy,
                                input logic gr, input logic [7:0] dout, input logic [1:0] bps);
        vec_t r;
        r.v0 = v0; r.d0 = d0; r.v1 = v1; r.d1 = d1; r.txs = txs; r.txd = txd;
        r.cw = cw; r.cb = cb; r.r0 = r0; r.r1 = r1; r.se = se; r.busy = busy;
        r.gr = gr; r.dout = dout; r.bps = bps;
        return r;
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        // inputs: v0 d0 v1 d1 txs txd cw cb | expected: r0 r1 se busy grant dout bps
        tbl[0]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 8'h00, 2'd0);
        tbl[1]  = mk(1, 8'h11, 0, 8'h00, 0, 0, 1, 2'd1, 0, 0, 0, 0, 0, 8'h00, 2'd0);
        tbl[2]  = mk(1, 8'h11, 0, 8'h00, 0, 0, 0, 2'd0, 1, 0, 0, 0, 0, 8'h00, 2'd1);
        tbl[3]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 2'd0, 0, 0, 1, 1, 0, 8'h11, 2'd1);
        tbl[4]  = mk(0, 8'h00, 1, 8'h22, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0, 8'h11, 2'd1);
        tbl[5]  = mk(0, 8'h00, 1, 8'h22, 0, 1, 0, 2'd0, 0, 0, 0, 1, 0, 8'h11, 2'd1);
        tbl[6]  = mk(0, 8'h00, 1, 8'h22, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 8'h11, 2'd1);
        tbl[7]  = mk(0, 8'h00, 1, 8'h22, 0, 0, 0, 2'd0, 0, 1, 0, 0, 0, 8'h11, 2'd1);
        tbl[8]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 2'd0, 0, 0, 1, 1, 1, 8'h22, 2'd1);
        tbl[9]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 2'd3, 0, 0, 0, 1, 1, 8'h22, 2'd1);
        tbl[10] = mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 2'd0, 0, 0, 0, 1, 1, 8'h22, 2'd1);
        tbl[11] = mk(1, 8'h33, 1, 8'h44, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1, 8'h22, 2'd1);
        tbl[12] = mk(1, 8'h33, 1, 8'h44, 0, 0, 0, 2'd0, 1, 0, 0, 0, 1, 8'h22, 2'd3);
        tbl[13] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 2'd0, 0, 0, 1, 1, 0, 8'h33, 2'd3);
        tbl[14] = mk(0, 8'h00, 1, 8'h44, 0, 1, 0, 2'd0, 0, 0, 0, 1, 0, 8'h33, 2'd3);
        tbl[15] = mk(1, 8'h55, 1, 8'h44, 0, 0, 0, 2'd0, 0, 1, 0, 0, 0, 8'h33, 2'd3);
        tbl[16] = mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 2'd0, 0, 0, 1, 1, 1, 8'h44, 2'd3);
        tbl[17] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 2'd0, 0, 0, 0, 1, 1, 8'h44, 2'd3);
        tbl[18] = mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 2'd0, 0, 0, 0, 1, 1, 8'h44, 2'd3);
        tbl[19] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1, 8'h44, 2'd3);

        do_reset();
        settle();
        chk("reset_outs", {ifa.req0_ready, ifa.req1_ready, ifa.send_en, ifa.busy, ifa.grant,
                           ifa.data_out, ifa.bps_set, ifa.timeout_err}, 0);

        // Table-driven cycle vectors
        for (int i = 0; i < 20; i++) begin
            v = tbl[i];
            ifa.req0_valid = v.v0; ifa.req0_data = v.d0;
            ifa.req1_valid = v.v1; ifa.req1_data = v.d1;
            ifa.tx_state = v.txs; ifa.tx_done = v.txd;
            ifa.cfg_wr = v.cw; ifa.cfg_bps = v.cb;
            settle();
            chk($sformatf("vec[%0d]", i),
                {ifa.req0_ready, ifa.req1_ready, ifa.send_en, ifa.busy, ifa.grant, ifa.data_out, ifa.bps_set},
                {v.r0, v.r1, v.se, v.busy, v.gr, v.dout, v.bps});
            step();
        end

        // Both requesters, tx_done 20 cycles after each send_en
        do_reset();
        ifa.req0_valid = 1; ifa.req0_data = 8'hA5;
        ifa.req1_valid = 1; ifa.req1_data = 8'h3C;
        nsend = 0; td = -1; se_run = 0; max_run = 0;
        sd[0] = 0; sd[1] = 0; sg[0] = 1'bx; sg[1] = 1'bx;
        for (int c = 0; c < 120; c++) begin
            ifa.tx_done = (c == td);
            settle();
            if (ifa.send_en) begin
                if (nsend < 2) begin
                    sd[nsend] = ifa.data_out;
                    sg[nsend] = ifa.grant;
                end
                nsend++;
                td = c + 20;
                se_run++;
                if (se_run > max_run) max_run = se_run;
            end else begin
                se_run = 0;
            end
            drop0 = ifa.req0_ready;
            drop1 = ifa.req1_ready;
            step();
            if (drop0) ifa.req0_valid = 0;
            if (drop1) ifa.req1_valid = 0;
        end
        chk("both_nsend", nsend, 2);
        chk("both_first", {sg[0], sd[0]}, {1'b0, 8'hA5});
        chk("both_second", {sg[1], sd[1]}, {1'b1, 8'h3C});
        chk("both_se_width", max_run, 1);

        // Lone requester 1 held for three bytes
        do_reset();
        ifa.req1_valid = 1; ifa.req1_data = 8'h10;
        na = 0; nd = 0; td = -1; bad0 = 0;
        for (int c = 0; c < 100; c++) begin
            ifa.tx_done = (c == td);
            if (ifa.tx_done && nd < 3) begin
                done_c[nd] = c;
                nd++;
            end
            settle();
            if (ifa.send_en) td = c + 5;
            if (ifa.req0_ready) bad0 = 1;
            drop1 = ifa.req1_ready;
            if (drop1) begin
                if (na < 3) acc_c[na] = c;
                na++;
            end
            step();
            if (drop1) begin
                if (na >= 3) ifa.req1_valid = 0;
                else ifa.req1_data = ifa.req1_data + 8'h01;
            end
        end
        chk("lone_count", na, 3);
        chk("lone_no_r0", bad0, 0);
        chk("lone_gap1", acc_c[1] - done_c[0], 1);
        chk("lone_gap2", acc_c[2] - done_c[1], 1);

        // Two config writes during WAIT: last one applied on first idle cycle
        do_reset();
        ifa.req0_valid = 1; ifa.req0_data = 8'h55;
        settle(); chk("cfg_acc0", ifa.req0_ready, 1); step();
        ifa.req0_valid = 0;
        settle(); chk("cfg_load", ifa.send_en, 1); step();
        ifa.cfg_wr = 1; ifa.cfg_bps = 2'b11; settle(); step();
        ifa.cfg_wr = 1; ifa.cfg_bps = 2'b10; settle(); step();
        ifa.cfg_wr = 0; ifa.tx_done = 1; ifa.req0_valid = 1; ifa.req0_data = 8'h77;
        settle(); chk("cfg_wait_bps", {ifa.bps_set, ifa.req0_ready}, {2'b00, 1'b0}); step();
        ifa.tx_done = 0;
        settle(); chk("cfg_idle1", {ifa.busy, ifa.req0_ready}, 0); step();
        settle(); chk("cfg_idle2", {ifa.bps_set, ifa.req0_ready}, {2'b10, 1'b1}); step();
        ifa.req0_valid = 0;
        settle(); chk("cfg_send", {ifa.send_en, ifa.data_out}, {1'b1, 8'h77}); step();

        // Watchdog (TO_CYCLES=8): tx_done in the expiring cycle wins
        do_reset();
        ift.req0_valid = 1; ift.req0_data = 8'h81;
        settle(); chk("to_acc0", ift.req0_ready, 1); step();
        ift.req0_valid = 0;
        settle(); step();
        for (int k = 1; k < 8; k++) begin settle(); step(); end
        ift.tx_done = 1; settle(); step();
        ift.tx_done = 0;
        settle(); chk("to_tie", {ift.busy, ift.timeout_err}, 0);
        // Now let it expire
        ift.req0_valid = 1; ift.req0_data = 8'h82;
        settle(); chk("to_acc1", ift.req0_ready, 1); step();
        ift.req0_valid = 0;
        settle(); step();
        for (int k = 1; k <= 8; k++) begin
            settle();
            chk($sformatf("to_wait%0d", k), {ift.busy, ift.timeout_err}, {1'b1, 1'b0});
            step();
        end
        settle(); chk("to_expired", {ift.busy, ift.timeout_err}, {1'b0, 1'b1});
        ift.req1_valid = 1; ift.req1_data = 8'h42;
        settle(); chk("to_next_acc", ift.req1_ready, 1); step();
        ift.req1_valid = 0;
        settle(); chk("to_next_send", {ift.send_en, ift.grant, ift.data_out, ift.timeout_err},
                      {1'b1, 1'b1, 8'h42, 1'b1});
        step();

        // Reset during WAIT, then tx_done in IDLE
        do_reset();
        settle(); chk("to_rst_clear", ift.timeout_err, 0);
        ifa.cfg_wr = 1; ifa.cfg_bps = 2'b01; settle(); step();
        ifa.cfg_wr = 0; ifa.req1_valid = 1; ifa.req1_data = 8'h99;
        settle(); chk("rst_acc1", ifa.req1_ready, 1); step();
        ifa.req1_valid = 0;
        settle(); step();
        settle(); step();
        rst = 1; settle(); step();
        rst = 0;
        settle(); chk("rst_wait_outs", {ifa.req0_ready, ifa.req1_ready, ifa.send_en, ifa.busy,
                                        ifa.grant, ifa.data_out, ifa.bps_set, ifa.timeout_err}, 0);
        ifa.tx_done = 1; settle(); step();
        ifa.tx_done = 0;
        settle(); chk("rst_txd_ignored", {ifa.busy, ifa.send_en}, 0);
        ifa.req0_valid = 1; ifa.req0_data = 8'hAA; ifa.req1_valid = 1; ifa.req1_data = 8'hBB;
        settle(); chk("rst_rr", {ifa.req0_ready, ifa.req1_ready}, 2'b10); step();
        ifa.req0_valid = 0; ifa.req1_valid = 0;
        settle(); chk("rst_send", {ifa.send_en, ifa.data_out}, {1'b1, 8'hAA}); step();

        // Reset during LOAD drops the byte with no send_en afterwards
        do_reset();
        ifa.req0_valid = 1; ifa.req0_data = 8'h5A;
        settle(); step();
        ifa.req0_valid = 0;
        settle(); rst = 1; step();
        rst = 0;
        settle(); chk("rst_load", {ifa.send_en, ifa.busy, ifa.data_out}, 0);

        // Randomized traffic against a timestamp-based reference model
        do_reset();
        m_rr = 0; m_pend = 0; m_pend_val = 0; m_bps = 0; m_dout = 0; m_grant = 0;
        in_fl = 0; last_acc = -10; td = -1;
        for (int c = 0; c < 3000; c++) begin
            if (!ifa.req0_valid && $urandom_range(0, 2) == 0) begin
                ifa.req0_valid = 1; ifa.req0_data = 8'($urandom);
            end
            if (!ifa.req1_valid && $urandom_range(0, 2) == 0) begin
                ifa.req1_valid = 1; ifa.req1_data = 8'($urandom);
            end
            ifa.tx_state = ($urandom_range(0, 3) == 0);
            ifa.tx_done  = (c == td) || ($urandom_range(0, 19) == 0);
            ifa.cfg_wr   = ($urandom_range(0, 9) == 0);
            ifa.cfg_bps  = 2'($urandom);
            settle();

            e_r0 = 0; e_r1 = 0;
            e_se = in_fl && (c == last_acc + 1);
            e_busy = in_fl;
            n_in = in_fl; n_bps = m_bps; n_dout = m_dout; n_grant = m_grant;
            if (!in_fl) begin
                if (m_pend || ifa.cfg_wr) begin
                    n_bps = ifa.cfg_wr ? ifa.cfg_bps : m_pend_val;
                    m_pend = 0;
                end else if ((ifa.req0_valid || ifa.req1_valid) && !ifa.tx_state) begin
                    w = (ifa.req0_valid && ifa.req1_valid) ? m_rr : ifa.req1_valid;
                    if (w) e_r1 = 1; else e_r0 = 1;
                    n_dout = w ? ifa.req1_data : ifa.req0_data;
                    n_grant = w;
                    m_rr = !w;
                    n_in = 1;
                    last_acc = c;
                end
            end else begin
                if (ifa.cfg_wr) begin
                    m_pend = 1;
                    m_pend_val = ifa.cfg_bps;
                end
                if (ifa.tx_done && c >= last_acc + 2) n_in = 0;
            end
            chk($sformatf("rand_cyc%0d", c),
                {ifa.req0_ready, ifa.req1_ready, ifa.send_en, ifa.busy, ifa.grant,
                 ifa.data_out, ifa.bps_set, ifa.timeout_err},
                {e_r0, e_r1, e_se, e_busy, m_grant, m_dout, m_bps, 1'b0});
            if (ifa.send_en) td = c + int'($urandom_range(1, 12));
            drop0 = ifa.req0_ready;
            drop1 = ifa.req1_ready;
            m_bps = n_bps; m_dout = n_dout; m_grant = n_grant; in_fl = n_in;
            step();
            if (drop0) ifa.req0_valid = 0;
            if (drop1) ifa.req1_valid = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter TO_CYCLES, default 200000, is the tx_done watchdog limit in clk cycles and is at least 2.
REQ-002 Port clk, input, 1 bit, is the single clock; all logic is rising-edge.
REQ-003 Port rst, input, 1 bit, is the reset: synchronous, active-high.
REQ-004 Port req0_valid, input, 1 bit, means requester 0 has a byte pending.
REQ-005 Port req0_data, input, 8 bits, is the requester 0 byte, stable while req0_valid=1.
REQ-006 Port req0_ready, output, 1 bit, is the requester 0 accept strobe; transfer occurs when valid&ready.
REQ-007 Ports req1_valid, req1_data and req1_ready SHALL match REQ-004 to REQ-006 for requester 1.
REQ-008 Port cfg_bps, input, 2 bits, is the requested baud select code.
REQ-009 Port cfg_wr, input, 1 bit, is the cfg_bps write strobe.
REQ-010 Port bps_set, output, 2 bits, is the baud select driven to the UART transmitter.
REQ-011 Port send_en, output, 1 bit, is the one-cycle transmit start pulse to the transmitter.
REQ-012 Port data_out, output, 8 bits, is the byte to the transmitter.
REQ-013 Port tx_done, input, 1 bit, is the transmitter end-of-frame pulse.
REQ-014 Port tx_state, input, 1 bit, is the transmitter busy flag.
REQ-015 Port grant, output, 1 bit, is the index of the most recently accepted requester.
REQ-016 Port busy, output, 1 bit, is 1 whenever the FSM is not in IDLE.
REQ-017 Port timeout_err, output, 1 bit, is a sticky watchdog flag.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD and WAIT.
REQ-019 IDLE SHALL accept a request only when at least one valid=1, tx_state=0 and no config is pending; it asserts the winner's ready that cycle, registers its data into data_out and grant, and moves to LOAD.
REQ-020 Arbitration SHALL be round-robin: rr pointer=0 gives requester 0 priority; after accepting requester k, rr SHALL become 1-k; a lone valid requester always wins.
REQ-021 ready SHALL be asserted only in IDLE, at most one requester per cycle, and never without the matching valid.
REQ-022 LOAD SHALL assert send_en=1 for exactly one cycle, clear the watchdog counter and go to WAIT; data_out SHALL hold until the next acceptance.
REQ-023 WAIT: tx_done=1 SHALL cause a return to IDLE; otherwise the counter increments, and when the count reaches TO_CYCLES-1 the block SHALL set timeout_err=1 and return to IDLE.
REQ-024 If tx_done and the timeout occur in the same cycle, tx_done SHALL win and timeout_err SHALL stay unchanged.
REQ-025 cfg_wr in IDLE with no pending config SHALL update bps_set on the next edge, and no acceptance is made in that cycle.
REQ-026 cfg_wr outside IDLE SHALL latch cfg_bps as pending; on the first IDLE cycle the pending value SHALL be applied to bps_set, with no acceptance that cycle; a later cfg_wr overwrites pending (last write wins).
REQ-027 tx_done while in IDLE or LOAD SHALL be ignored.
REQ-028 Minimum acceptance spacing SHALL be 3 cycles plus the frame time; there SHALL be no buffering beyond data_out.
REQ-029 timeout_err SHALL clear only on rst.

Reset
REQ-030 While rst=1 at an edge, the block SHALL go to IDLE with rr=0, pending cleared, counter=0, bps_set=2'b00, send_en=0, data_out=8'h00, grant=0, busy=0, timeout_err=0, and both ready=0.
REQ-031 rst asserted in LOAD or WAIT SHALL abort without a send_en pulse on the next cycle; an in-flight byte is dropped.

Verification
REQ-032 Both valid with data 8'hA5 and 8'h3C, tx_done 20 cycles after send_en: expect A5 sent first (grant=0), then 3C (grant=1), with send_en high for 1 cycle each.
REQ-033 Only req1_valid held continuously for 3 bytes: expect 3 acceptances on requester 1, with each ready following the previous tx_done by 1 cycle.
REQ-034 cfg_wr with cfg_bps=2'b11 during WAIT, then 2'b10 also during WAIT: expect bps_set=2'b10 applied in the first IDLE cycle and the next acceptance 1 cycle later.
REQ-035 TO_CYCLES=8 with tx_done never asserted: expect timeout_err=1 at the 8th WAIT cycle, return to IDLE, and the next request served.
REQ-036 rst pulsed in WAIT, then tx_done pulsed in IDLE: expect all outputs at reset values, no send_en, and tx_done ignored.
